// File: rtl/switch_pkg.sv
// Shared definitions for the switch ingress path: header layout and
// arbiter state encoding.
package switch_pkg;

    localparam int         HDR_BYTES = 3;
    localparam logic [1:0] LEN_IDX   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Rotate-priority encoder: picks the first asserted request at or after ptr,
// wrapping cyclically over NUM_SRC entries.
module rr_select #(
    parameter  int NUM_SRC = 4,
    localparam int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any
);

    localparam logic [IW:0] N_W = (IW + 1)'(NUM_SRC);

    logic [NUM_SRC-1:0] rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;

    // Bit i of rot is req[(ptr + i) mod NUM_SRC].
    assign rot = NUM_SRC'({req, req} >> ptr);

    always_comb begin
        any    = 1'b0;
        off    = '0;
        winner = '0;
        sum    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            winner = IW'(sum - N_W);
        end else begin
            winner = IW'(sum);
        end
    end

endmodule

// File: rtl/ingress_arbiter.sv
// Packet-level round-robin arbiter feeding the switch's byte-wide ingress.
// A grant is held for one whole packet (DA, SA, LEN, LEN payload bytes).
module ingress_arbiter
    import switch_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IW      = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SRC-1:0][7:0] src_data,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [NUM_SRC-1:0]      src_en,
    output logic [7:0]              data,
    output logic                    data_status,
    input  logic                    fifo_full,
    output logic [IW-1:0]           grant_id,
    output logic                    busy,
    output logic                    pkt_done
);

    localparam logic [IW-1:0] LAST_SRC = IW'(NUM_SRC - 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [1:0]    hdr_cnt;
    logic [7:0]    pay_cnt;
    logic [7:0]    len_reg;
    logic [7:0]    cur_byte;
    logic          xfer;
    logic          last_byte;
    logic [IW-1:0] sel_winner;
    logic          sel_any;

    rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
        .req    (src_valid & src_en),
        .ptr    (rr_ptr),
        .winner (sel_winner),
        .any    (sel_any)
    );

    assign busy = (state != IDLE);

    always_comb begin
        cur_byte  = src_data[grant_id];
        xfer      = busy && src_valid[grant_id] && !fifo_full;
        src_ready = '0;
        if (busy && !fifo_full) begin
            src_ready[grant_id] = 1'b1;
        end
        data        = xfer ? cur_byte : 8'h00;
        data_status = xfer;
        last_byte   = 1'b0;
        state_nxt   = state;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (xfer && hdr_cnt == LEN_IDX) begin
                    last_byte = (cur_byte == 8'h00);
                    state_nxt = last_byte ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer && pay_cnt == len_reg - 8'd1) begin
                    last_byte = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pkt_done = last_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            hdr_cnt  <= '0;
            pay_cnt  <= '0;
            len_reg  <= '0;
        end else begin
            if (state == IDLE && sel_any) begin
                grant_id <= sel_winner;
                hdr_cnt  <= '0;
                pay_cnt  <= '0;
            end
            if (xfer && state == HDR) begin
                hdr_cnt <= hdr_cnt + 2'd1;
                if (hdr_cnt == LEN_IDX) begin
                    len_reg <= cur_byte;
                    pay_cnt <= '0;
                end
            end
            if (xfer && state == PAYLOAD) begin
                pay_cnt <= pay_cnt + 8'd1;
            end
            // Next arbitration starts just past the source that finished.
            if (last_byte) begin
                rr_ptr <= (grant_id == LAST_SRC) ? '0 : grant_id + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ingress_arbiter.sv
// Directed bench for ingress_arbiter: queue-based sources, per-cycle checks
// of the switch-side byte stream, grants and packet boundaries.
module tb_ingress_arbiter;

    localparam int NUM_SRC = 4;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_SRC-1:0][7:0] src_data;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0]      src_ready;
    logic [NUM_SRC-1:0]      src_en;
    logic [7:0]              data;
    logic                    data_status;
    logic                    fifo_full;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    pkt_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q [NUM_SRC][$];

    logic       o_ds, o_pd, o_busy;
    logic [7:0] o_data;
    logic [1:0] o_gid;
    logic [3:0] o_rdy;

    ingress_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_en      (src_en),
        .data        (data),
        .data_status (data_status),
        .fifo_full   (fifo_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_done    (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int g = 0; g < NUM_SRC; g++) begin
            src_valid[g] = (q[g].size() != 0);
            src_data[g]  = (q[g].size() != 0) ? q[g][0] : 8'h00;
        end
    endtask

    task automatic clear_src();
        for (int g = 0; g < NUM_SRC; g++) q[g].delete();
        drive_src();
    endtask

    // Sample outputs mid-cycle, then advance the granted source on a transfer.
    task automatic cyc();
        @(negedge clk);
        o_ds   = data_status;
        o_data = data;
        o_pd   = pkt_done;
        o_gid  = grant_id;
        o_busy = busy;
        o_rdy  = src_ready;
        @(posedge clk);
        #1;
        if (o_ds) void'(q[o_gid].pop_front());
        drive_src();
    endtask

    task automatic load_pkt(input int g, input logic [7:0] da, input logic [7:0] sa,
                            input logic [7:0] len, input logic [7:0] base);
        q[g].push_back(da);
        q[g].push_back(sa);
        q[g].push_back(len);
        for (int i = 0; i < int'(len); i++) q[g].push_back(base + 8'(i));
        drive_src();
    endtask

    task automatic expect_gap();
        cyc();
        chk("gap_ds", o_ds, 0);
        chk("gap_busy", o_busy, 0);
    endtask

    task automatic expect_byte(input int g, input logic [7:0] b, input logic last);
        cyc();
        chk("ds", o_ds, 1);
        chk("data", o_data, b);
        chk("grant", o_gid, g);
        chk("pkt_done", o_pd, last);
        chk("ready", o_rdy, 32'(1) << g);
    endtask

    task automatic expect_pkt(input int g, input logic [7:0] da, input logic [7:0] sa,
                              input logic [7:0] len, input logic [7:0] base);
        expect_gap();
        expect_byte(g, da, 1'b0);
        expect_byte(g, sa, 1'b0);
        expect_byte(g, len, len == 8'h00);
        for (int i = 0; i < int'(len); i++)
            expect_byte(g, base + 8'(i), i == int'(len) - 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        src_en    = 4'hF;
        clear_src();

        // Reset state
        cyc();
        chk("rst_busy", o_busy, 0);
        chk("rst_ds", o_ds, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_ready", o_rdy, 0);
        chk("rst_pdone", o_pd, 0);
        chk("rst_grant", o_gid, 0);
        reset_n = 1'b1;

        // Single source 0, LEN=2
        load_pkt(0, 8'h11, 8'h22, 8'h02, 8'hA0);
        expect_pkt(0, 8'h11, 8'h22, 8'h02, 8'hA0);
        expect_gap();
        chk("rr_ptr_after_src0", 32'(dut.rr_ptr), 1);

        // LEN=0 from source 2
        load_pkt(2, 8'h33, 8'h44, 8'h00, 8'h00);
        expect_pkt(2, 8'h33, 8'h44, 8'h00, 8'h00);
        expect_gap();

        // All four requesting, LEN=1, from a fresh rr pointer
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int g = 0; g < NUM_SRC; g++) load_pkt(g, 8'hD0 + 8'(g), 8'h50 + 8'(g), 8'h01, 8'hE0 + 8'(g));
        load_pkt(0, 8'hC8, 8'h58, 8'h01, 8'hE8);
        expect_pkt(0, 8'hD0, 8'h50, 8'h01, 8'hE0);
        expect_pkt(1, 8'hD1, 8'h51, 8'h01, 8'hE1);
        expect_pkt(2, 8'hD2, 8'h52, 8'h01, 8'hE2);
        expect_pkt(3, 8'hD3, 8'h53, 8'h01, 8'hE3);
        expect_pkt(0, 8'hC8, 8'h58, 8'h01, 8'hE8);
        expect_gap();

        // fifo_full stall in the middle of the payload
        load_pkt(1, 8'h01, 8'h02, 8'h04, 8'hC0);
        expect_gap();
        expect_byte(1, 8'h01, 1'b0);
        expect_byte(1, 8'h02, 1'b0);
        expect_byte(1, 8'h04, 1'b0);
        expect_byte(1, 8'hC0, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("full_ds", o_ds, 0);
            chk("full_ready", o_rdy, 0);
            chk("full_busy", o_busy, 1);
        end
        fifo_full = 1'b0;
        expect_byte(1, 8'hC1, 1'b0);
        expect_byte(1, 8'hC2, 1'b0);
        expect_byte(1, 8'hC3, 1'b1);
        expect_gap();

        // src_en=1010: rr_ptr is 2 here, so 3 wins first, then 1, then 3
        src_en = 4'b1010;
        for (int g = 0; g < NUM_SRC; g++) load_pkt(g, 8'h70 + 8'(g), 8'h60 + 8'(g), 8'h01, 8'h90 + 8'(g));
        load_pkt(1, 8'h71, 8'h61, 8'h01, 8'h99);
        load_pkt(3, 8'h73, 8'h63, 8'h01, 8'h9B);
        expect_pkt(3, 8'h73, 8'h63, 8'h01, 8'h93);
        expect_gap();
        expect_byte(1, 8'h71, 1'b0);
        src_en = 4'b1000;
        expect_byte(1, 8'h61, 1'b0);
        expect_byte(1, 8'h01, 1'b0);
        expect_byte(1, 8'h91, 1'b1);
        expect_pkt(3, 8'h73, 8'h63, 8'h01, 8'h9B);
        for (int i = 0; i < 3; i++) expect_gap();
        clear_src();
        src_en = 4'hF;

        // Reset mid-payload; rr_ptr is 2 just before, so source 3 would win without reset
        load_pkt(1, 8'hB1, 8'hB2, 8'h00, 8'h00);
        expect_pkt(1, 8'hB1, 8'hB2, 8'h00, 8'h00);
        load_pkt(2, 8'hD2, 8'h52, 8'h03, 8'hF0);
        expect_gap();
        expect_byte(2, 8'hD2, 1'b0);
        expect_byte(2, 8'h52, 1'b0);
        expect_byte(2, 8'h03, 1'b0);
        expect_byte(2, 8'hF0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ds", data_status, 0);
        chk("arst_data", data, 8'h00);
        chk("arst_ready", src_ready, 0);
        chk("arst_pdone", pkt_done, 0);
        chk("arst_grant", grant_id, 0);
        cyc();
        chk("arst_hold_busy", o_busy, 0);
        clear_src();
        load_pkt(3, 8'hA3, 8'hB3, 8'h01, 8'hC3);
        load_pkt(1, 8'hA1, 8'hB1, 8'h01, 8'hC1);
        reset_n = 1'b1;
        expect_pkt(1, 8'hA1, 8'hB1, 8'h01, 8'hC1);
        expect_pkt(3, 8'hA3, 8'hB3, 8'h01, 8'hC3);
        expect_gap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ingress_arbiter.md
# ingress_arbiter

Packet-level round-robin arbiter that shares the switch's single byte-wide ingress (`data`/`data_status`) among NUM_SRC upstream sources. It grants one source at a time, holds the grant for exactly one whole packet (DA, SA, LEN, then LEN payload bytes), and throttles on the switch's `fifo_full`. It sits directly in front of `switch` and drives that block's `data` and `data_status` inputs.

## Interface
- NUM_SRC, default 4, number of upstream sources (2..8)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- src_data  input  NUM_SRC x 8  per-source current byte
- src_valid  input  NUM_SRC  per-source byte valid
- src_ready  output  NUM_SRC  per-source byte accepted this cycle
- src_en  input  NUM_SRC  per-source arbitration enable (config)
- data  output  8  byte to switch ingress
- data_status  output  1  write strobe to switch FIFO
- fifo_full  input  1  switch FIFO full
- grant_id  output  $clog2(NUM_SRC)  currently or last granted source
- busy  output  1  packet transfer in progress
- pkt_done  output  1  one-cycle pulse on last byte of a packet

## Operation
- Byte transfer on source g: `src_valid[g] && src_ready[g]`.
- `src_ready[g] = (state != IDLE) && (grant_id == g) && !fifo_full`; all other bits 0.
- `data = src_data[grant_id]` when a transfer occurs, else 8'h00. `data_status` = transfer. Both are combinational from registered state, so no skid byte is produced when `fifo_full` asserts.
- State machine:
  - IDLE: candidates = `src_valid & src_en`. If any candidate exists, choose the first one at or after `rr_ptr`, cyclic. Register it into `grant_id`, clear counters, go to HDR. Otherwise stay in IDLE.
  - HDR: `hdr_cnt` (2 bits) increments on each transfer. On the transfer with `hdr_cnt==2`, capture `len_reg <= src_data[grant_id]`. If that byte is 0, the packet ends (go to IDLE). Otherwise go to PAYLOAD with `pay_cnt=0`.
  - PAYLOAD: `pay_cnt` (8 bits) increments on each transfer. On the transfer with `pay_cnt == len_reg-1`, the packet ends (go to IDLE).
  - Packet end: `pkt_done` pulses and `rr_ptr <= grant_id+1`, wrapping modulo NUM_SRC.
- A stalled granted source (`src_valid` low mid-packet) or `fifo_full` holds the state; the FSM never times out or aborts.
- Deasserting `src_en[g]` mid-packet does not abort the transfer; it only excludes g from later arbitration.
- `busy = (state != IDLE)`.
- Widths: LEN is 8 bits, so the maximum packet is 258 bytes. Counters do not wrap within a packet.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `len_reg` 0, `busy` 0, `pkt_done` 0, `src_ready` all 0, `data_status` 0, `data` 8'h00.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N allows the first transfer in cycle N+1.
- After a packet end, the FSM spends one cycle in IDLE before the next grant. The minimum gap between packets is therefore 1 cycle with `data_status` low.
- Throughput within a packet: 1 byte/cycle while `src_valid` is high and `fifo_full` is low.
- `fifo_full` and `data_status` may both be combinationally relevant in the same cycle. A byte is written only when `fifo_full` is low in that cycle.
- `pkt_done` is asserted in the same cycle as the last byte's `data_status`.
- Asynchronous reset mid-packet: all outputs go to their reset values immediately. Any partial packet already in the switch FIFO is not this block's concern.

## Structure
- Shared package `switch_pkg`:
  - `HDR_BYTES=3`, `LEN_IDX=2`
  - typedef `arb_state_t {IDLE, HDR, PAYLOAD}`
- Sub-module `rr_select`: combinational rotate-priority encoder. Inputs are the request vector and `rr_ptr`; outputs are `winner` index and `any`.

## Test plan
- Single source 0 sends DA=8'h11, SA=8'h22, LEN=8'h02, payload 8'hA0, 8'hA1. Expect 5 consecutive `data_status` pulses with those bytes, `pkt_done` on 8'hA1, then `rr_ptr=1`.
- LEN=0 packet from source 2. Expect exactly 3 bytes, `pkt_done` on the LEN byte, and return to IDLE.
- All 4 sources requesting continuously with LEN=1 packets. Expect grant order 0,1,2,3,0, a 1-cycle gap between packets, and no byte interleaving.
- Assert `fifo_full` for 4 cycles in the middle of the payload. Expect `src_ready` and `data_status` low for those 4 cycles, no dropped or duplicated bytes, and resumption the cycle `fifo_full` drops.
- `src_en=4'b1010` with all sources valid. Expect grants only to sources 1 and 3, alternating. Clearing `src_en[1]` mid-packet still completes that packet.
- Assert `reset_n` low during a payload byte. Expect outputs at reset values and `busy` 0 immediately. After release, arbitration restarts from source 0.
